// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: default parameters and count-width helper for fifo_sync_gen
// Holds constants and a pure function only; no state.
package fifo_sync_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_AFULL_TH = 6;
  localparam int DEF_AEMPTY_TH = 2;
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port storage, DATA_W x 2**ADDR_W, synchronous write
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
// Default build: registered read on re, rdata cleared by rst.
// FIFO_SYNC_FWFT_EN: asynchronous read, rst/re ports absent.
module fifo_sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
`ifndef FIFO_SYNC_FWFT_EN
  input  logic              rst,
  input  logic              re,
`endif
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
`ifdef FIFO_SYNC_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/fifo_sync_gen.sv
// fifo_sync_gen: synchronous FIFO with occupancy flags and sticky error flags
// Ports: clk, rst (sync, active-high); wre/din write; rde/dout read;
// full/empty/afull/aempty/count occupancy (state after the edge); ovf/udf sticky errors.
// Macro FIFO_SYNC_FWFT_EN selects first-word fall-through; default is one-cycle read latency.
import fifo_sync_pkg::*;
module fifo_sync_gen #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AFULL_TH = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wre,
  input  logic                rde,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                full,
  output logic                empty,
  output logic                afull,
  output logic                aempty,
  output logic [ADDR_W:0]     count,
  output logic                ovf,
  output logic                udf
);
  localparam int CW = cnt_w(ADDR_W);
  logic [CW-1:0] wptr, rptr;
  logic we, re;
  logic [DATA_W-1:0] rdata;
  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty = wptr == rptr;
  assign count = wptr - rptr;
  assign afull = count >= CW'(AFULL_TH);
  assign aempty = count <= CW'(AEMPTY_TH);
  assign we = wre && !full && !rst;
  assign re = rde && !empty && !rst;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      wptr <= wptr + CW'(we);
      rptr <= rptr + CW'(re);
      ovf <= ovf | (wre & full);
      udf <= udf | (rde & empty);
    end
  fifo_sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
`ifndef FIFO_SYNC_FWFT_EN
    .rst(rst),
    .re(re),
`endif
    .we(we),
    .waddr(wptr[ADDR_W-1:0]),
    .wdata(din),
    .raddr(rptr[ADDR_W-1:0]),
    .rdata(rdata)
  );
`ifdef FIFO_SYNC_FWFT_EN
  assign dout = empty ? '0 : rdata;
`else
  assign dout = rdata;
`endif
endmodule
